// File: rtl/dmem_ctrl.sv
// Data-memory controller: host LOAD stream, core RUN window, host DUMP stream.
// Optional DMEM_ERR_EN adds a sticky out-of-range access flag (err).
module dmem_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             start,
   input  logic [WIDTH:0]   load_len,
   input  logic [WIDTH-1:0] dump_base,
   input  logic [WIDTH:0]   dump_len,
   input  logic [WIDTH-1:0] hst_in_data,
   input  logic             hst_in_valid,
   output logic             hst_in_ready,
   output logic [WIDTH-1:0] hst_out_data,
   output logic             hst_out_valid,
   input  logic             hst_out_ready,
   output logic             core_run,
   input  logic             core_done,
   input  logic [WIDTH-1:0] DRAM_addr,
   input  logic [WIDTH-1:0] DRAM_dataOut,
   input  logic             memREAD,
   input  logic             memWRITE,
   output logic [WIDTH-1:0] DRAM_dataIn,
   output logic             busy,
`ifdef DMEM_ERR_EN
   output logic             err,
`endif
   output logic             done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WIDTH:0] DEPTH_W = (WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP} state_t;
   state_t state, state_next;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [WIDTH:0]   load_len_q, dump_len_q, wptr, cnt;
   logic [WIDTH-1:0] dump_base_q, rptr, rd_data, out_data;
   logic             out_valid, done_q, done_next;
   logic             in_fire, last_in, out_fire, fetch;
   logic             core_in_range, rptr_in_range, core_wr, core_rd, skip_dump;

   // Handshake: a beat transfers on a rising edge where valid and ready are both high;
   // the sender holds data stable while valid is high and ready is low.
   assign in_fire       = (state == S_LOAD) && hst_in_valid;
   assign last_in       = in_fire && (wptr == load_len_q - (WIDTH+1)'(1));
   assign out_fire      = out_valid && hst_out_ready;
   assign fetch         = (state == S_DUMP) && (cnt != '0) && (!out_valid || hst_out_ready);
   assign core_in_range = ({1'b0, DRAM_addr} < DEPTH_W);
   assign rptr_in_range = ({1'b0, rptr} < DEPTH_W);
   assign core_wr       = (state == S_RUN) && memWRITE && core_in_range;
   assign core_rd       = (state == S_RUN) && memREAD;

`ifdef DMEM_ERR_EN
   logic err_q, err_now;
   assign err_now   = ((state == S_RUN) && (memREAD || memWRITE) && !core_in_range) ||
                      (fetch && !rptr_in_range);
   assign skip_dump = err_q || err_now;
   assign err       = err_q;
`else
   assign skip_dump = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         S_IDLE: if (start) state_next = (load_len == '0) ? S_RUN : S_LOAD;
         S_LOAD: if (last_in) state_next = S_RUN;
         S_RUN: begin
            if (core_done) begin
               if ((dump_len_q == '0) || skip_dump) begin
                  state_next = S_IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = S_DUMP;
               end
            end
         end
         S_DUMP: begin
            if (out_fire && (cnt == '0)) begin
               state_next = S_IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         if (in_fire)      mem[wptr[AW-1:0]]      <= hst_in_data;
         else if (core_wr) mem[DRAM_addr[AW-1:0]] <= DRAM_dataOut;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         load_len_q  <= '0;
         dump_len_q  <= '0;
         dump_base_q <= '0;
         wptr        <= '0;
         rptr        <= '0;
         cnt         <= '0;
         rd_data     <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         done_q      <= 1'b0;
`ifdef DMEM_ERR_EN
         err_q       <= 1'b0;
`endif
      end else begin
         done_q <= done_next;
         if ((state == S_IDLE) && start) begin
            load_len_q  <= load_len;
            dump_base_q <= dump_base;
            dump_len_q  <= dump_len;
            wptr        <= '0;
         end
         if (in_fire) wptr <= wptr + (WIDTH+1)'(1);
         // Read-before-write: the registered read sees the pre-edge RAM word.
         if (core_rd) rd_data <= core_in_range ? mem[DRAM_addr[AW-1:0]] : '0;
         if ((state == S_RUN) && (state_next == S_DUMP)) begin
            rptr      <= dump_base_q;
            cnt       <= dump_len_q;
            out_valid <= 1'b0;
         end
         // Output register doubles as the prefetch stage for 1 beat/cycle.
         if (fetch) begin
            out_data  <= rptr_in_range ? mem[rptr[AW-1:0]] : '0;
            out_valid <= 1'b1;
            rptr      <= rptr + WIDTH'(1);
            cnt       <= cnt - (WIDTH+1)'(1);
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end
`ifdef DMEM_ERR_EN
         if ((state == S_IDLE) && start) err_q <= 1'b0;
         else if (err_now)               err_q <= 1'b1;
`endif
      end
   end

   assign hst_in_ready  = (state == S_LOAD);
   assign core_run      = (state == S_RUN);
   assign busy          = (state != S_IDLE);
   assign done          = done_q;
   assign hst_out_valid = out_valid;
   assign hst_out_data  = out_data;
   assign DRAM_dataIn   = rd_data;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: load, core access, dump with stalls, reset mid-job.
// With DMEM_ERR_EN defined the DUT is built with DEPTH=128 and the err flag is exercised.
module tb_dmem_ctrl;
   localparam int WIDTH = 8;
`ifdef DMEM_ERR_EN
   localparam int DEPTH = 128;
`else
   localparam int DEPTH = 256;
`endif

   logic             Clk, Rst, start;
   logic [WIDTH:0]   load_len, dump_len;
   logic [WIDTH-1:0] dump_base, hst_in_data, hst_out_data;
   logic             hst_in_valid, hst_in_ready, hst_out_valid, hst_out_ready;
   logic             core_run, core_done, memREAD, memWRITE, busy, done;
   logic [WIDTH-1:0] DRAM_addr, DRAM_dataOut, DRAM_dataIn;
`ifdef DMEM_ERR_EN
   logic             err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] ld [4];
   int acc;

   dmem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .load_len(load_len),
      .dump_base(dump_base), .dump_len(dump_len),
      .hst_in_data(hst_in_data), .hst_in_valid(hst_in_valid), .hst_in_ready(hst_in_ready),
      .hst_out_data(hst_out_data), .hst_out_valid(hst_out_valid), .hst_out_ready(hst_out_ready),
      .core_run(core_run), .core_done(core_done),
      .DRAM_addr(DRAM_addr), .DRAM_dataOut(DRAM_dataOut),
      .memREAD(memREAD), .memWRITE(memWRITE), .DRAM_dataIn(DRAM_dataIn),
      .busy(busy),
`ifdef DMEM_ERR_EN
      .err(err),
`endif
      .done(done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_job(input logic [WIDTH:0] ll, input logic [WIDTH-1:0] db,
                            input logic [WIDTH:0] dl);
      start = 1'b1; load_len = ll; dump_base = db; dump_len = dl;
      tick();
      start = 1'b0;
   endtask

   task automatic load_stream(input int n, input bit toggle, output int accepted);
      int  cyc;
      bit  accept;
      cyc = 0;
      accepted = 0;
      while (accepted < n && cyc < 64) begin
         hst_in_valid = toggle ? ((cyc % 2) == 1) : 1'b1;
         hst_in_data  = ld[accepted];
         accept = hst_in_valid && hst_in_ready;
         tick();
         if (accept) accepted++;
         cyc++;
      end
      hst_in_valid = 1'b0;
      if (accepted < n) check("load_timeout", accepted, n);
   endtask

   task automatic core_write(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
      DRAM_addr = a; DRAM_dataOut = d; memWRITE = 1'b1;
      tick();
      memWRITE = 1'b0;
   endtask

   task automatic core_read(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] e, input string tag);
      DRAM_addr = a; memREAD = 1'b1;
      tick();
      memREAD = 1'b0;
      check(tag, DRAM_dataIn, e);
   endtask

   task automatic pulse_core_done();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
   endtask

   // Called one cycle after the core_done edge; drains exp_q through the dump stream.
   task automatic dump_collect(input int stall_beat, input int stall_cycles);
      int n, got, cyc, stalled, first_cyc, last_cyc;
      logic [WIDTH-1:0] held;
      n = exp_q.size(); got = 0; cyc = 0; stalled = 0; first_cyc = -1; last_cyc = -1;
      held = '0;
      while (got < n && cyc < 100) begin
         if (got == stall_beat && stalled < stall_cycles) begin
            hst_out_ready = 1'b0;
            if (hst_out_valid) begin
               if (stalled == 0) held = hst_out_data;
               else check("stall_stable", hst_out_data, held);
            end
            stalled++;
         end else begin
            hst_out_ready = 1'b1;
         end
         if (hst_out_valid && hst_out_ready) begin
            check($sformatf("beat%0d", got), hst_out_data, exp_q.pop_front());
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            got++;
         end
         tick();
         cyc++;
      end
      hst_out_ready = 1'b0;
      check("dump_beats", got, n);
      check("dump_first_latency", (first_cyc >= 0) && (first_cyc <= 2), 1);
      if (stall_beat < 0) check("dump_back_to_back", last_cyc - first_cyc, n - 1);
      check("dump_done", done, 1);
      check("dump_busy", busy, 0);
      check("dump_valid_low", hst_out_valid, 0);
      tick();
      check("done_one_cycle", done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst = 1'b1; start = 1'b0; load_len = '0; dump_base = '0; dump_len = '0;
      hst_in_data = '0; hst_in_valid = 1'b0; hst_out_ready = 1'b0; core_done = 1'b0;
      DRAM_addr = '0; DRAM_dataOut = '0; memREAD = 1'b0; memWRITE = 1'b0;
      repeat (2) tick();
      Rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_in_ready", hst_in_ready, 0);
      check("rst_out_valid", hst_out_valid, 0);
      check("rst_core_run", core_run, 0);
      check("rst_done", done, 0);
      check("rst_dataIn", DRAM_dataIn, 0);
      check("rst_out_data", hst_out_data, 0);

`ifndef DMEM_ERR_EN
      // Job 1: toggled load, core access, wrapping dump.
      ld[0] = 8'h11; ld[1] = 8'h22; ld[2] = 8'h33; ld[3] = 8'h44;
      start_job(9'd4, 8'hFE, 9'd3);
      check("load_ready", hst_in_ready, 1);
      load_stream(4, 1'b1, acc);
      check("load_count", acc, 4);
      check("load_to_run", core_run, 1);
      check("load_ready_drop", hst_in_ready, 0);
      core_read(8'h00, 8'h11, "load_mem0");
      core_read(8'h01, 8'h22, "load_mem1");
      core_read(8'h03, 8'h44, "load_mem3");
      core_write(8'h02, 8'hA5);
      core_read(8'h02, 8'hA5, "wr_then_rd");
      DRAM_addr = 8'h02; DRAM_dataOut = 8'h5A; memREAD = 1'b1; memWRITE = 1'b1;
      tick();
      memREAD = 1'b0; memWRITE = 1'b0;
      check("rbw_old", DRAM_dataIn, 8'hA5);
      core_read(8'h02, 8'h5A, "rbw_new");
      tick();
      check("read_hold", DRAM_dataIn, 8'h5A);
      core_write(8'hFE, 8'hC3);
      core_write(8'hFF, 8'h7E);
      exp_q.push_back(8'hC3); exp_q.push_back(8'h7E); exp_q.push_back(8'h11);
      pulse_core_done();
      dump_collect(-1, 0);

      // Strobes and core_done in IDLE must be ignored.
      DRAM_addr = 8'hFE; DRAM_dataOut = 8'hEE; memWRITE = 1'b1; memREAD = 1'b1;
      tick();
      memWRITE = 1'b0; memREAD = 1'b0;
      check("idle_read_ignored", DRAM_dataIn, 8'h5A);
      pulse_core_done();
      check("idle_done_ignored_busy", busy, 0);
      check("idle_done_ignored_done", done, 0);

      // Job 2: reset after two of four load beats.
      ld[0] = 8'h99; ld[1] = 8'h98; ld[2] = 8'h97; ld[3] = 8'h96;
      start_job(9'd4, 8'h00, 9'd4);
      load_stream(2, 1'b0, acc);
      check("pre_rst_ready", hst_in_ready, 1);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      check("midrst_in_ready", hst_in_ready, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      tick();
      check("midrst_no_done", done, 0);

      // Job 3: reload from address 0, dump with a 5-cycle stall.
      ld[0] = 8'hA0; ld[1] = 8'hA1; ld[2] = 8'hA2; ld[3] = 8'hA3;
      start_job(9'd4, 8'h00, 9'd4);
      load_stream(4, 1'b0, acc);
      check("job3_run", core_run, 1);
      core_read(8'h00, 8'hA0, "reload_addr0");
      core_read(8'h03, 8'hA3, "reload_addr3");
      core_read(8'hFE, 8'hC3, "idle_write_dropped");
      exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
      exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
      pulse_core_done();
      dump_collect(1, 5);

      // Job 4: zero-length load and dump; start while busy is ignored.
      start_job(9'd0, 8'h10, 9'd0);
      check("zero_load_run", core_run, 1);
      start_job(9'd5, 8'h20, 9'd2);
      check("busy_start_run", core_run, 1);
      check("busy_start_ready", hst_in_ready, 0);
      pulse_core_done();
      check("zero_dump_done", done, 1);
      check("zero_dump_busy", busy, 0);
      check("zero_dump_valid", hst_out_valid, 0);
      tick();
      check("zero_dump_done_clr", done, 0);
`else
      check("err_rst", err, 0);
      start_job(9'd0, 8'h00, 9'd1);
      check("err_run", core_run, 1);
      core_read(8'h90, 8'h00, "oor_read_zero");
      check("err_set", err, 1);
      pulse_core_done();
      check("err_skip_done", done, 1);
      check("err_skip_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         check("err_no_beat", hst_out_valid, 0);
         tick();
      end
      check("err_sticky", err, 1);
      start_job(9'd0, 8'h00, 9'd0);
      check("err_cleared", err, 0);
      pulse_core_done();
      check("err_job2_done", done, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory subsystem directly downstream of the processor core's DRAM port (DRAM_addr/DRAM_dataOut/memREAD/memWRITE in, DRAM_dataIn out).
- Owns the data RAM and sequences one job: host streams operand matrices in (LOAD), core runs (RUN), then the host streams the result window out (DUMP).
- Gives the host a valid/ready byte-stream interface and gates the core with a run flag.

Parameters:
- WIDTH, 8, data and address width; matches core WIDTH.
- DEPTH, 256, RAM words; must be <= 2**WIDTH.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- start  in  1  job start pulse; honoured only in IDLE.
- load_len  in  WIDTH+1  words to load from address 0 (0..DEPTH).
- dump_base  in  WIDTH  first address to dump.
- dump_len  in  WIDTH+1  words to dump (0..DEPTH).
- hst_in_data  in  WIDTH  load stream data.
- hst_in_valid  in  1  load stream valid.
- hst_in_ready  out  1  load stream ready.
- hst_out_data  out  WIDTH  dump stream data.
- hst_out_valid  out  1  dump stream valid.
- hst_out_ready  in  1  dump stream ready.
- core_run  out  1  high while the core may execute.
- core_done  in  1  pulse from core CU at end of program.
- DRAM_addr  in  WIDTH  core address (core AR).
- DRAM_dataOut  in  WIDTH  core write data (core DR).
- memREAD  in  1  core read strobe.
- memWRITE  in  1  core write strobe.
- DRAM_dataIn  out  WIDTH  read data to core.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a job completes.

Behaviour:
- Reset: state IDLE. hst_in_ready, hst_out_valid, core_run, busy and done = 0. DRAM_dataIn and hst_out_data = 0. Pointers and counters = 0. RAM contents are not cleared.
- FSM states are IDLE, LOAD, RUN and DUMP.
- IDLE:
  - start latches load_len, dump_base and dump_len.
  - Next state is LOAD (wptr = 0), or RUN directly if load_len == 0.
- LOAD:
  - hst_in_ready = 1.
  - Each valid&ready beat writes mem[wptr] and then increments wptr.
  - The beat with wptr == load_len-1 moves the FSM to RUN on the next cycle; hst_in_ready drops in that same cycle.
  - Stalls on hst_in_valid are unbounded.
- RUN:
  - core_run = 1.
  - memWRITE: mem[DRAM_addr] <= DRAM_dataOut at the edge.
  - memREAD: DRAM_dataIn <= mem[DRAM_addr], registered, valid the cycle after the strobe, and held until the next read.
  - memREAD and memWRITE to the same address in the same cycle: the write lands and the read returns the old data (read-before-write).
  - core_done moves the FSM to DUMP (rptr = dump_base, cnt = dump_len). If dump_len == 0, it instead returns to IDLE with done = 1.
- Core strobes outside RUN are ignored: no RAM write, DRAM_dataIn holds.
- core_done outside RUN is ignored.
- DUMP:
  - hst_out_valid first asserts no later than 2 cycles after entering DUMP.
  - hst_out_data holds stable while valid&!ready.
  - With hst_out_ready held high, throughput is 1 beat/cycle (prefetch register required).
  - rptr increments per handshake and wraps modulo 2**WIDTH.
  - After the final handshake: hst_out_valid = 0, done = 1 for one cycle, return to IDLE.
- start while busy: ignored, latched lengths are unchanged.
- Rst mid-job: immediate return to IDLE. All outputs take their reset values, and done is not pulsed.
- Core addresses >= DEPTH: writes dropped, reads return 0 (base behaviour).

Optional Feature:
- Macro: DMEM_ERR_EN.
- When defined:
  - Adds output err (1 bit).
  - err is sticky and set on any RUN-state core access with DRAM_addr >= DEPTH, or any DUMP address >= DEPTH.
  - err is cleared only by Rst or by start accepted in IDLE.
  - When err is set at core_done, DUMP is skipped and the FSM goes to IDLE with done = 1.
- When undefined: no err port, and out-of-range accesses behave as base (dropped/0) with no flag.

Test Plan:
- Load 4 bytes 0x11,0x22,0x33,0x44 (load_len=4) with hst_in_valid toggling every other cycle -> exactly 4 writes, RUN entered the cycle after the 4th beat, core_run=1.
- In RUN, memWRITE addr 0x02 data 0xA5, then memREAD 0x02 -> DRAM_dataIn=0xA5 one cycle after the read strobe. Then memREAD+memWRITE addr 0x02 data 0x5A in the same cycle -> read returns 0xA5, and a later read returns 0x5A.
- core_done with dump_base=0xFE, dump_len=3, hst_out_ready=1 -> beats mem[0xFE], mem[0xFF], mem[0x00] on consecutive cycles, then done pulse, busy=0.
- hst_out_ready low for 5 cycles mid-dump -> hst_out_data stable, no beat lost or duplicated.
- Rst asserted during LOAD after 2 of 4 beats -> next cycle IDLE, hst_in_ready=0, no done pulse. A new start then reloads from address 0.
- DMEM_ERR_EN, DEPTH=128: memREAD addr 0x90 in RUN -> err=1, DRAM_dataIn=0. core_done -> done pulse with no dump beats.
